// File: rtl/bus_rr_arbiter16_pkg.sv
// ============================================================================
// arb_pkg : shared constants, state type and round-robin search helper
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  localparam int NREQ  = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // Scans last+1, last+2, ... wrapping; with excl set, last itself is never picked.
  function automatic rr_pick_t next_rr(input logic [NREQ-1:0]  req,
                                       input logic [SEL_W-1:0] last,
                                       input logic             excl);
    rr_pick_t         pick;
    logic [SEL_W-1:0] idx;
    pick.found = 1'b0;
    pick.idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = last + SEL_W'(i);
      if (!pick.found && req[idx] && !(excl && (idx == last))) begin
        pick.found = 1'b1;
        pick.idx   = idx;
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/busMux16_1.sv
// ============================================================================
// busMux16_1 : 16:1 bus multiplexer, out = in[sel]
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module busMux16_1 #(
  parameter int WIDTH = 64
) (
  input  logic [3:0]             sel_i,
  input  logic [15:0][WIDTH-1:0] in_i,
  output logic [WIDTH-1:0]       out_o
);

  assign out_o = in_i[sel_i];

endmodule

`default_nettype wire

// File: rtl/bus_rr_arbiter16.sv
// ============================================================================
// bus_rr_arbiter16 : round-robin arbiter with hold quantum driving a 16:1 mux
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bus_rr_arbiter16
  import arb_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            req,
  input  logic [15:0][WIDTH-1:0] in,
  output logic [15:0]            gnt,
  output logic [3:0]             sel,
  output logic                   valid,
  output logic [WIDTH-1:0]       bus_out
);

  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  arb_state_t        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;

  rr_pick_t          pick_any;
  rr_pick_t          pick_oth;
  logic [NREQ-1:0]   owner_oh;
  logic              others_pending;
  logic              quantum_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(NREQ - 1);
      hold_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    last_d         = last_q;
    hold_d         = hold_q;
    pick_any       = next_rr(req, last_q, 1'b0);
    pick_oth       = next_rr(req, last_q, 1'b1);
    owner_oh       = NREQ'(1) << sel_q;
    others_pending = (req & ~owner_oh) != '0;
    quantum_done   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    case (state_q)
      IDLE: begin
        if (pick_any.found) begin
          state_d = BUSY;
          sel_d   = pick_any.idx;
          last_d  = pick_any.idx;
          hold_d  = '0;
        end
      end
      BUSY: begin
        if (!req[sel_q]) begin
          // Release hands over on the same edge so the bus never idles needlessly.
          hold_d = '0;
          if (pick_any.found) begin
            sel_d  = pick_any.idx;
            last_d = pick_any.idx;
          end else begin
            state_d = IDLE;
          end
        end else if (quantum_done && others_pending) begin
          sel_d  = pick_oth.idx;
          last_d = pick_oth.idx;
          hold_d = '0;
        end else if ((MAX_HOLD != 0) && (hold_q != HOLD_LAST)) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    gnt_d = (state_d == BUSY) ? (NREQ'(1) << sel_d) : '0;
  end

  always_comb begin
    gnt   = gnt_q;
    sel   = sel_q;
    valid = |gnt_q;
  end

  busMux16_1 #(.WIDTH(WIDTH)) u_mux (
    .sel_i (sel_q),
    .in_i  (in),
    .out_o (bus_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_bus_rr_arbiter16.sv
// ============================================================================
// tb_bus_rr_arbiter16 : randomized + directed bench against an ownership model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_bus_rr_arbiter16;

  localparam int WIDTH    = 64;
  localparam int MAX_HOLD = 8;

  logic                   clk;
  logic                   reset;
  logic [15:0]            req;
  logic [15:0][WIDTH-1:0] din;
  logic [15:0]            gnt;
  logic [3:0]             sel;
  logic                   valid;
  logic [WIDTH-1:0]       bus_out;

  int errors = 0;
  int checks = 0;

  // Model: owner index (-1 = nobody), last granted index, cycles held so far.
  int m_owner = -1;
  int m_last  = 15;
  int m_held  = 0;
  int m_wait [16];
  bit m_was_reset;
  bit chk_starve = 0;

  bus_rr_arbiter16 #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .in      (din),
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .bus_out (bus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int find_next(input logic [15:0] r, input int last, input bit excl);
    for (int k = 1; k <= 16; k++) begin
      int idx;
      idx = (last + k) % 16;
      if (!(excl && idx == last) && r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [15:0] r, input logic rs);
    int w;
    m_was_reset = rs;
    if (rs) begin
      m_owner = -1;
      m_last  = 15;
      m_held  = 0;
    end else if (m_owner < 0 || !r[m_owner]) begin
      w = find_next(r, m_last, 1'b0);
      m_owner = w;
      m_held  = (w < 0) ? 0 : 1;
      if (w >= 0) m_last = w;
    end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD && (r & ~(16'(1) << m_owner)) != 16'h0) begin
      w = find_next(r, m_last, 1'b1);
      m_owner = w;
      m_last  = w;
      m_held  = 1;
    end else begin
      m_held++;
    end
    for (int i = 0; i < 16; i++) begin
      if (!rs && r[i] && m_owner != i) m_wait[i]++;
      else m_wait[i] = 0;
    end
  endtask

  task automatic compare_all();
    logic [15:0] exp_gnt;
    int maxw;
    exp_gnt = (m_owner < 0) ? 16'h0 : (16'(1) << m_owner);
    check("gnt", 64'(gnt), 64'(exp_gnt));
    check("valid", 64'(valid), 64'(m_owner >= 0));
    check("onehot0", 64'($onehot0(gnt)), 64'd1);
    check("valid_or", 64'(valid), 64'(|gnt));
    if (m_owner >= 0) begin
      check("sel", 64'(sel), 64'(m_owner));
      check("bus_out", bus_out, din[m_owner]);
    end
    if (m_was_reset) check("sel_reset", 64'(sel), 64'd0);
    if (chk_starve) begin
      maxw = 0;
      for (int i = 0; i < 16; i++) if (m_wait[i] > maxw) maxw = m_wait[i];
      check("starve", 64'(maxw <= 15 * MAX_HOLD + 1), 64'd1);
    end
  endtask

  task automatic step(input logic [15:0] r, input logic rs);
    req   = r;
    reset = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
    compare_all();
  endtask

  initial begin
    logic [15:0] r;
    reset = 1'b1;
    req   = 16'h0;
    for (int i = 0; i < 16; i++) begin
      din[i] = {$urandom, $urandom};
      m_wait[i] = 0;
    end

    // Reset and idle
    step(16'h0, 1'b1);
    step(16'h0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step(16'h0, 1'b0);
      check("idle_gnt", 64'(gnt), 64'h0);
      check("idle_valid", 64'(valid), 64'h0);
      check("idle_sel", 64'(sel), 64'h0);
    end

    // Single request, data path
    din[4] = 64'hDEAD_BEEF;
    step(16'h0010, 1'b0);
    check("req4_gnt", 64'(gnt), 64'h0010);
    check("req4_sel", 64'(sel), 64'd4);
    check("req4_bus", bus_out, 64'hDEAD_BEEF);
    step(16'h0000, 1'b0);
    check("req4_release", 64'(valid), 64'd0);

    // Two persistent requesters alternate by quantum
    step(16'h0, 1'b1);
    for (int c = 0; c < 24; c++) begin
      step(16'h8001, 1'b0);
      check("q8001", 64'(gnt), ((c / 8) % 2 == 1) ? 64'h8000 : 64'h0001);
    end

    // All requesting: 0..15,0 with MAX_HOLD each
    step(16'h0, 1'b1);
    chk_starve = 1;
    for (int c = 0; c < 17 * MAX_HOLD; c++) begin
      step(16'hFFFF, 1'b0);
      check("all_owner", 64'(sel), 64'((c / MAX_HOLD) % 16));
    end
    chk_starve = 0;

    // Release with another waiting: no bubble
    step(16'h0, 1'b1);
    step(16'h0008, 1'b0);
    check("own3", 64'(gnt), 64'h0008);
    step(16'h0208, 1'b0);
    step(16'h0208, 1'b0);
    step(16'h0200, 1'b0);
    check("hand_3_9", 64'(gnt), 64'h0200);
    check("hand_valid", 64'(valid), 64'd1);

    // Reset mid-ownership restores last=15
    step(16'h0, 1'b1);
    step(16'h0080, 1'b0);
    step(16'h0080, 1'b0);
    check("own7", 64'(sel), 64'd7);
    step(16'h0080, 1'b1);
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_valid", 64'(valid), 64'd0);
    step(16'h0081, 1'b0);
    check("after_rst", 64'(gnt), 64'h0001);

    // Single persistent requester keeps the bus
    step(16'h0, 1'b1);
    for (int c = 0; c < 30; c++) begin
      step(16'h0020, 1'b0);
      check("persist", 64'(gnt), 64'h0020);
    end

    // Randomized traffic
    r = 16'h0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 16; i++) din[i] = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       r = 16'($urandom) & 16'($urandom);
        1:       r = 16'($urandom);
        2:       r = r ^ (16'(1) << $urandom_range(0, 15));
        3:       r = 16'h0;
        default: r = r;
      endcase
      step(r, ($urandom_range(0, 149) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
